// File: rtl/mmu_cmd_sequencer.sv
// Initiator for a 4x4 MMU: turns one GEMM tile job into RESET/[SET_CONV_MODE]/TRIGGER/FORWARD
// commands with operand beats, then drains the four result columns to a valid/ready stream.
module mmu_cmd_sequencer #(
  parameter int unsigned ACLEN        = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned KLEN_W       = 16,
  parameter int unsigned FLUSH_CYCLES = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      job_valid_i,
  output logic                      job_ready_o,
  input  logic [KLEN_W-1:0]         job_k_i,
  input  logic                      job_conv_i,
  input  logic                      op_valid_i,
  output logic                      op_ready_o,
  input  logic [4*DATA_WIDTH-1:0]   op_data_i,
  input  logic [4*DATA_WIDTH-1:0]   op_weight_i,
  output logic                      mmu_cmd_valid_o,
  output logic [ACLEN:0]            mmu_cmd_o,
  output logic [DATA_WIDTH-1:0]     data_1_o,
  output logic [DATA_WIDTH-1:0]     data_2_o,
  output logic [DATA_WIDTH-1:0]     data_3_o,
  output logic [DATA_WIDTH-1:0]     data_4_o,
  output logic [DATA_WIDTH-1:0]     weight_1_o,
  output logic [DATA_WIDTH-1:0]     weight_2_o,
  output logic [DATA_WIDTH-1:0]     weight_3_o,
  output logic [DATA_WIDTH-1:0]     weight_4_o,
  input  logic [4*DATA_WIDTH-1:0]   mmu_rdata_1_i,
  input  logic [4*DATA_WIDTH-1:0]   mmu_rdata_2_i,
  input  logic [4*DATA_WIDTH-1:0]   mmu_rdata_3_i,
  input  logic [4*DATA_WIDTH-1:0]   mmu_rdata_4_i,
  input  logic                      mmu_busy_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [4*DATA_WIDTH-1:0]   res_data_o,
  output logic [1:0]                res_col_o,
  output logic                      res_last_o,
  output logic                      busy_o
);

  localparam int unsigned LW = 4 * DATA_WIDTH;
  localparam int unsigned CW = ACLEN + 1;
  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [CW-1:0] CMD_RESET        = CW'(0);
  localparam logic [CW-1:0] CMD_TRIGGER      = CW'(1);
  localparam logic [CW-1:0] CMD_TRIGGER_LAST = CW'(2);
  localparam logic [CW-1:0] CMD_SET_CONV     = CW'(6);
  localparam logic [CW-1:0] CMD_FORWARD      = CW'(8);

  // The state names the phase whose command is registered at the next edge, so the
  // RESET beat itself is issued on the job handshake and operands are accepted while
  // the preceding command is on the bus, giving back-to-back commands.
  typedef enum logic [2:0] {
    S_IDLE,
    S_MODE,
    S_FEED,
    S_FLUSH,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t                state_reg;
  logic [KLEN_W-1:0]     k_reg;
  logic [KLEN_W-1:0]     beat_reg;
  logic [FW-1:0]         flush_reg;
  logic [1:0]            col_reg;
  logic                  cmd_valid_reg;
  logic [CW-1:0]         cmd_reg;
  logic [DATA_WIDTH-1:0] data_reg   [4];
  logic [DATA_WIDTH-1:0] weight_reg [4];
  logic [LW-1:0]         cap_reg    [4];

  logic [DATA_WIDTH-1:0] op_data_lane   [4];
  logic [DATA_WIDTH-1:0] op_weight_lane [4];
  logic [LW-1:0]         rdata_col      [4];
  logic                  op_hs;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign op_data_lane[gi]   = op_data_i[LW-1-gi*DATA_WIDTH -: DATA_WIDTH];
      assign op_weight_lane[gi] = op_weight_i[LW-1-gi*DATA_WIDTH -: DATA_WIDTH];
    end
  endgenerate

  assign rdata_col[0] = mmu_rdata_1_i;
  assign rdata_col[1] = mmu_rdata_2_i;
  assign rdata_col[2] = mmu_rdata_3_i;
  assign rdata_col[3] = mmu_rdata_4_i;

  assign op_ready_o = (state_reg == S_FEED) && !mmu_busy_i;
  assign op_hs      = op_ready_o && op_valid_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= S_IDLE;
      k_reg         <= '0;
      beat_reg      <= '0;
      flush_reg     <= '0;
      col_reg       <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_reg       <= '0;
      for (int i = 0; i < 4; i++) begin
        data_reg[i]   <= '0;
        weight_reg[i] <= '0;
        cap_reg[i]    <= '0;
      end
    end else begin
      cmd_valid_reg <= 1'b0;
      cmd_reg       <= '0;
      for (int i = 0; i < 4; i++) begin
        data_reg[i]   <= '0;
        weight_reg[i] <= '0;
      end

      case (state_reg)
        S_IDLE: begin
          if (job_valid_i) begin
            k_reg         <= job_k_i;
            beat_reg      <= '0;
            flush_reg     <= '0;
            cmd_valid_reg <= 1'b1;
            cmd_reg       <= CMD_RESET;
            if (job_conv_i) begin
              state_reg <= S_MODE;
            end else if (job_k_i != '0) begin
              state_reg <= S_FEED;
            end else begin
              // k=0: skip the flush entirely, just leave one idle bus cycle
              state_reg <= S_FLUSH;
              flush_reg <= FW'(FLUSH_CYCLES);
            end
          end
        end

        S_MODE: begin
          cmd_valid_reg <= 1'b1;
          cmd_reg       <= CMD_SET_CONV;
          if (k_reg != '0) begin
            state_reg <= S_FEED;
          end else begin
            state_reg <= S_FLUSH;
            flush_reg <= FW'(FLUSH_CYCLES);
          end
        end

        S_FEED: begin
          if (op_hs) begin
            cmd_valid_reg <= 1'b1;
            for (int i = 0; i < 4; i++) begin
              data_reg[i]   <= op_data_lane[i];
              weight_reg[i] <= op_weight_lane[i];
            end
            beat_reg <= beat_reg + KLEN_W'(1);
            if (beat_reg == k_reg - KLEN_W'(1)) begin
              cmd_reg   <= CMD_TRIGGER_LAST;
              state_reg <= S_FLUSH;
            end else begin
              cmd_reg <= CMD_TRIGGER;
            end
          end
        end

        S_FLUSH: begin
          if (flush_reg == FW'(FLUSH_CYCLES)) begin
            state_reg <= S_WAIT;
          end else if (!mmu_busy_i) begin
            cmd_valid_reg <= 1'b1;
            cmd_reg       <= CMD_FORWARD;
            flush_reg     <= flush_reg + FW'(1);
          end
        end

        S_WAIT: begin
          if (!mmu_busy_i) begin
            state_reg <= S_DRAIN;
            col_reg   <= '0;
            for (int i = 0; i < 4; i++) begin
              cap_reg[i] <= rdata_col[i];
            end
          end
        end

        S_DRAIN: begin
          if (res_ready_i) begin
            if (col_reg == 2'd3) begin
              state_reg <= S_IDLE;
              col_reg   <= '0;
            end else begin
              col_reg <= col_reg + 2'd1;
            end
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign mmu_cmd_valid_o = cmd_valid_reg;
  assign mmu_cmd_o       = cmd_reg;
  assign data_1_o        = data_reg[0];
  assign data_2_o        = data_reg[1];
  assign data_3_o        = data_reg[2];
  assign data_4_o        = data_reg[3];
  assign weight_1_o      = weight_reg[0];
  assign weight_2_o      = weight_reg[1];
  assign weight_3_o      = weight_reg[2];
  assign weight_4_o      = weight_reg[3];

  assign job_ready_o = (state_reg == S_IDLE);
  assign busy_o      = (state_reg != S_IDLE);
  assign res_valid_o = (state_reg == S_DRAIN);
  assign res_col_o   = col_reg;
  assign res_last_o  = res_valid_o && (col_reg == 2'd3);
  assign res_data_o  = res_valid_o ? cap_reg[col_reg] : '0;

endmodule

// File: tb/tb_mmu_cmd_sequencer.sv
// Directed bench for mmu_cmd_sequencer: expected commands and result beats are queued when a
// job is launched and checked by monitors as the DUT produces them.
module tb_mmu_cmd_sequencer;

  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          job_valid_i;
  logic          job_ready_o;
  logic [15:0]   job_k_i;
  logic          job_conv_i;
  logic          op_valid_i;
  logic          op_ready_o;
  logic [127:0]  op_data_i;
  logic [127:0]  op_weight_i;
  logic          mmu_cmd_valid_o;
  logic [8:0]    mmu_cmd_o;
  logic [31:0]   data_1_o, data_2_o, data_3_o, data_4_o;
  logic [31:0]   weight_1_o, weight_2_o, weight_3_o, weight_4_o;
  logic [127:0]  mmu_rdata_1_i, mmu_rdata_2_i, mmu_rdata_3_i, mmu_rdata_4_i;
  logic          mmu_busy_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [127:0]  res_data_o;
  logic [1:0]    res_col_o;
  logic          res_last_o;
  logic          busy_o;

  typedef struct {
    logic [8:0]   cmd;
    logic [127:0] d;
    logic [127:0] w;
  } exp_cmd_t;

  typedef struct {
    logic [127:0] d;
    logic [1:0]   col;
    logic         last;
  } exp_res_t;

  typedef struct {
    logic [127:0] d;
    logic [127:0] w;
  } op_beat_t;

  exp_cmd_t cmd_q[$];
  exp_res_t res_q[$];
  op_beat_t op_q[$];
  int       cyc_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int trig_count = 0;
  int first_res_cyc = -1;
  int hs_cyc = 0;
  logic [31:0] stub_base = 32'd0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  mmu_cmd_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_k_i(job_k_i), .job_conv_i(job_conv_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_data_i(op_data_i), .op_weight_i(op_weight_i),
    .mmu_cmd_valid_o(mmu_cmd_valid_o), .mmu_cmd_o(mmu_cmd_o),
    .data_1_o(data_1_o), .data_2_o(data_2_o), .data_3_o(data_3_o), .data_4_o(data_4_o),
    .weight_1_o(weight_1_o), .weight_2_o(weight_2_o),
    .weight_3_o(weight_3_o), .weight_4_o(weight_4_o),
    .mmu_rdata_1_i(mmu_rdata_1_i), .mmu_rdata_2_i(mmu_rdata_2_i),
    .mmu_rdata_3_i(mmu_rdata_3_i), .mmu_rdata_4_i(mmu_rdata_4_i),
    .mmu_busy_i(mmu_busy_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_col_o(res_col_o), .res_last_o(res_last_o),
    .busy_o(busy_o)
  );

  // MMU result stub: column n, lane j (lane0 in MSBs) = n*0x11111111 + base*(j+1)
  function automatic logic [127:0] stub_col(input int n, input logic [31:0] base);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      r[127-32*j -: 32] = 32'(n) * 32'h1111_1111 + base * 32'(j + 1);
    return r;
  endfunction

  assign mmu_rdata_1_i = stub_col(1, stub_base);
  assign mmu_rdata_2_i = stub_col(2, stub_base);
  assign mmu_rdata_3_i = stub_col(3, stub_base);
  assign mmu_rdata_4_i = stub_col(4, stub_base);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Command monitor
  always @(negedge clk_i) begin
    logic [127:0] d_obs, w_obs;
    exp_cmd_t e;
    d_obs = {data_1_o, data_2_o, data_3_o, data_4_o};
    w_obs = {weight_1_o, weight_2_o, weight_3_o, weight_4_o};
    if (mmu_cmd_valid_o === 1'b1) begin
      cyc_q.push_back(cyc);
      if (mmu_cmd_o == 9'd1 || mmu_cmd_o == 9'd2) trig_count++;
      chk("cmd_expected", 128'(cmd_q.size() != 0), 128'(1));
      if (cmd_q.size() != 0) begin
        e = cmd_q.pop_front();
        chk("cmd_code", 128'(mmu_cmd_o), 128'(e.cmd));
        chk("cmd_data", d_obs, e.d);
        chk("cmd_weight", w_obs, e.w);
      end
    end else begin
      chk("idle_lanes", d_obs | w_obs, 128'(0));
    end
  end

  // Result monitor
  always @(negedge clk_i) begin
    exp_res_t e;
    if (res_valid_o === 1'b1 && first_res_cyc < 0) first_res_cyc = cyc;
    if (res_valid_o === 1'b1 && res_ready_i === 1'b1) begin
      chk("res_expected", 128'(res_q.size() != 0), 128'(1));
      if (res_q.size() != 0) begin
        e = res_q.pop_front();
        chk("res_data", res_data_o, e.d);
        chk("res_col", 128'(res_col_o), 128'(e.col));
        chk("res_last", 128'(res_last_o), 128'(e.last));
      end
    end
  end

  // Operand source: presents the head of op_q, pops it after each accepted beat
  initial begin
    logic op_hs;
    op_valid_i  = 1'b0;
    op_data_i   = '0;
    op_weight_i = '0;
    forever begin
      @(negedge clk_i);
      op_hs = op_valid_i && op_ready_o;
      @(posedge clk_i);
      #1;
      if (op_hs && op_q.size() > 0) void'(op_q.pop_front());
      if (op_q.size() > 0) begin
        op_valid_i  = 1'b1;
        op_data_i   = op_q[0].d;
        op_weight_i = op_q[0].w;
      end else begin
        op_valid_i  = 1'b0;
        op_data_i   = '0;
        op_weight_i = '0;
      end
    end
  end

  task automatic start_job(input int k, input bit conv);
    op_beat_t b;
    cmd_q.push_back('{cmd: 9'd0, d: '0, w: '0});
    if (conv) cmd_q.push_back('{cmd: 9'd6, d: '0, w: '0});
    for (int i = 0; i < k; i++) begin
      b.d = {$urandom, $urandom, $urandom, $urandom};
      b.w = {$urandom, $urandom, $urandom, $urandom};
      op_q.push_back(b);
      cmd_q.push_back('{cmd: (i == k - 1) ? 9'd2 : 9'd1, d: b.d, w: b.w});
    end
    if (k > 0) for (int i = 0; i < 6; i++) cmd_q.push_back('{cmd: 9'd8, d: '0, w: '0});
    for (int c = 0; c < 4; c++)
      res_q.push_back('{d: stub_col(c + 1, stub_base), col: 2'(c), last: (c == 3)});
    cyc_q.delete();
    first_res_cyc = -1;
    trig_count    = 0;
    @(posedge clk_i); #1;
    job_k_i     = 16'(k);
    job_conv_i  = conv;
    job_valid_i = 1'b1;
    hs_cyc      = cyc;
    @(posedge clk_i); #1;
    job_valid_i = 1'b0;
    job_k_i     = '0;
    job_conv_i  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    for (n = 0; n < 400 && !(job_ready_o && cmd_q.size() == 0 && res_q.size() == 0); n++)
      @(negedge clk_i);
    chk({tag, "_done_in_time"}, 128'(n < 400), 128'(1));
    chk({tag, "_job_ready"}, 128'(job_ready_o), 128'(1));
    chk({tag, "_busy"}, 128'(busy_o), 128'(0));
  endtask

  initial begin
    int n;
    logic [127:0] held;
    rst_i       = 1'b0;
    job_valid_i = 1'b0;
    job_k_i     = '0;
    job_conv_i  = 1'b0;
    mmu_busy_i  = 1'b0;
    res_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_job_ready", 128'(job_ready_o), 128'(1));
    chk("rst_cmd_valid", 128'(mmu_cmd_valid_o), 128'(0));
    chk("rst_res_valid", 128'(res_valid_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    // 1: k=1, conv=0, back-to-back commands
    start_job(1, 1'b0);
    wait_done("t1");
    chk("t1_cmd_count", 128'(cyc_q.size()), 128'(8));
    for (int i = 0; i < cyc_q.size() && i < 8; i++)
      chk("t1_cmd_cycle", 128'(cyc_q[i]), 128'(hs_cyc + 1 + i));
    chk("t1_res_latency", 128'(first_res_cyc >= hs_cyc + 9), 128'(1));

    // 2: k=4, conv=1, lane ordering
    start_job(4, 1'b1);
    wait_done("t2");
    chk("t2_trig_count", 128'(trig_count), 128'(4));

    // 3: k=8 with a 3-cycle busy window mid-FEED
    start_job(8, 1'b0);
    for (n = 0; n < 100 && trig_count < 3; n++) @(negedge clk_i);
    chk("t3_reach_feed", 128'(n < 100), 128'(1));
    @(posedge clk_i); #1;
    mmu_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t3_op_ready_busy", 128'(op_ready_o), 128'(0));
      if (i > 0) chk("t3_no_cmd", 128'(mmu_cmd_valid_o), 128'(0));
      if (i < 2) begin @(posedge clk_i); #1; end
    end
    @(posedge clk_i); #1;
    mmu_busy_i = 1'b0;
    @(negedge clk_i);
    chk("t3_no_cmd", 128'(mmu_cmd_valid_o), 128'(0));
    wait_done("t3");
    chk("t3_trig_count", 128'(trig_count), 128'(8));

    // 4: backpressure at col 1, result must stay captured while rdata changes
    stub_base   = 32'd0;
    res_ready_i = 1'b0;
    start_job(2, 1'b0);
    for (n = 0; n < 100 && !res_valid_o; n++) @(negedge clk_i);
    chk("t4_reach_drain", 128'(n < 100), 128'(1));
    @(posedge clk_i); #1;
    res_ready_i = 1'b1;
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    held = stub_col(2, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("t4_hold_valid", 128'(res_valid_o), 128'(1));
      chk("t4_hold_col", 128'(res_col_o), 128'(1));
      chk("t4_hold_data", res_data_o, held);
      if (i == 1) stub_base = 32'h0000_0077;
      @(posedge clk_i); #1;
    end
    res_ready_i = 1'b1;
    wait_done("t4");

    // 5: k=0, RESET only
    start_job(0, 1'b0);
    wait_done("t5");
    chk("t5_cmd_count", 128'(cyc_q.size()), 128'(1));
    chk("t5_trig_count", 128'(trig_count), 128'(0));

    // 6: asynchronous reset during FEED, then a clean restart
    start_job(8, 1'b0);
    for (n = 0; n < 100 && trig_count < 2; n++) @(negedge clk_i);
    chk("t6_reach_feed", 128'(n < 100), 128'(1));
    #2;
    rst_i = 1'b0;
    #1;
    chk("t6_cmd_valid", 128'(mmu_cmd_valid_o), 128'(0));
    chk("t6_cmd", 128'(mmu_cmd_o), 128'(0));
    chk("t6_data", {data_1_o, data_2_o, data_3_o, data_4_o}, 128'(0));
    chk("t6_weight", {weight_1_o, weight_2_o, weight_3_o, weight_4_o}, 128'(0));
    chk("t6_op_ready", 128'(op_ready_o), 128'(0));
    chk("t6_res_valid", 128'(res_valid_o), 128'(0));
    chk("t6_busy", 128'(busy_o), 128'(0));
    chk("t6_job_ready", 128'(job_ready_o), 128'(1));
    cmd_q.delete();
    res_q.delete();
    op_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    start_job(2, 1'b0);
    wait_done("t6");
    chk("t6_restart_cmds", 128'(cyc_q.size()), 128'(9));
    chk("t6_restart_first", 128'((cyc_q.size() > 0) ? cyc_q[0] : -1), 128'(hs_cyc + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
